seq_multiplier_8bit: RTL and testbench

//  Sequential 8x8 unsigned shift-and-add multiplier, upstream driver of the adder_8bit ripple adder.

---
 rtl/seq_multiplier_8bit_pkg.sv | 18 +
 rtl/adder_8bit.sv | 26 ++
 rtl/seq_multiplier_8bit.sv | 96 +++++++++
 tb/tb_seq_multiplier_8bit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_multiplier_8bit_pkg.sv
// Shared constants and FSM encoding for the 8x8 shift-and-add multiplier.
// WIDTH is fixed at 8 by adder_8bit; CNT_W counts the eight add/shift steps.
package seq_multiplier_8bit_pkg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 3;
  localparam int PW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Value the step counter holds during the last add/shift step.
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

endpackage

// File: rtl/adder_8bit.sv
// 8-bit ripple-carry adder, purely combinational.
// Ports: a_i, b_i (8b addends), cin_i (carry in) -> sum_o (8b), cout_o.
module adder_8bit
  import seq_multiplier_8bit_pkg::*;
(
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  always_comb begin
    logic c;
    c     = cin_i;
    sum_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c;
      c = (a_i[i] & b_i[i])
        | (a_i[i] & c)
        | (b_i[i] & c);
    end
    cout_o = c;
  end

endmodule

// File: rtl/seq_multiplier_8bit.sv
// Sequential 8x8 unsigned shift-and-add multiplier feeding adder_8bit.
// Ports: clk, rst_n (async low), start, a, b -> product (16b), busy, done.
module seq_multiplier_8bit
  import seq_multiplier_8bit_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [PW-1:0]    product,
  output logic             busy,
  output logic             done
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [PW-1:0]      p_q, p_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]      prod_q, prod_d;

  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic [PW-1:0]      step_p;

  // Upper half of P accumulates; the multiplier bit
  // in P[0] selects whether mcand is added this step.
  assign add_b = p_q[0] ? mcand_q : '0;

  adder_8bit u_add (
    .a_i    (p_q[PW-1:WIDTH]),
    .b_i    (add_b),
    .cin_i  (1'b0),
    .sum_o  (sum),
    .cout_o (cout)
  );

  // Carry lands in P[15], so 0xFF*0xFF cannot overflow.
  assign step_p = {cout, sum, p_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mcand_q <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a;
          p_d     = {{WIDTH{1'b0}}, b};
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        p_d   = step_p;
        cnt_d = cnt_q + CNT_W'(1);
        // Capture the value being written to P,
        // not the stale P of this cycle.
        if (cnt_q == LAST_STEP) begin
          prod_d  = step_p;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign product = prod_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_seq_multiplier_8bit.sv
// Self-checking bench for seq_multiplier_8bit.
// Expected products are queued on accept and popped at done.
module tb_seq_multiplier_8bit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] product;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] sb[$];
  logic [15:0] last_exp = 16'h0000;

  seq_multiplier_8bit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pop_check(input string nm);
    logic [15:0] e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: done with empty queue, product=%h",
               nm, product);
    end else begin
      e = sb.pop_front();
      last_exp = e;
      if (product !== e) begin
        n_fail++;
        $display("FAIL %s: product=%h expected=%h",
                 nm, product, e);
      end
    end
  endtask

  task automatic chk_bd(input string nm, input int k,
                        input logic eb, input logic ed);
    n_tests++;
    if (busy !== eb) begin
      n_fail++;
      $display("FAIL %s busy k=%0d: got=%b expected=%b",
               nm, k, busy, eb);
    end
    n_tests++;
    if (done !== ed) begin
      n_fail++;
      $display("FAIL %s done k=%0d: got=%b expected=%b",
               nm, k, done, ed);
    end
  endtask

  // One operation from an idle DUT. Accept at edge N; done
  // must be seen only in the cycle after edge N+8, busy for
  // the nine cycles after N. Inputs are scrambled after accept.
  task automatic run_op(input logic [7:0] ta,
                        input logic [7:0] tb,
                        input bit noisy,
                        input string nm);
    @(negedge clk);
    start = 1'b1;
    a = ta;
    b = tb;
    @(posedge clk);
    sb.push_back({8'h00, ta} * {8'h00, tb});
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = (noisy && k < 9) ? 1'($urandom_range(0, 1)) : 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
      chk_bd(nm, k, k <= 9, k == 9);
      if (k == 9) pop_check(nm);
      if (k == 10) begin
        n_tests++;
        if (product !== last_exp) begin
          n_fail++;
          $display("FAIL %s hold: product=%h expected=%h",
                   nm, product, last_exp);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    a = 8'hAA;
    b = 8'h55;
    repeat (3) @(negedge clk);
    chk_bd("reset_low", 0, 1'b0, 1'b0);
    n_tests++;
    if (product !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_low product: got=%h expected=0000",
               product);
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk_bd("reset_rel", 0, 1'b0, 1'b0);
    n_tests++;
    if (product !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_rel product: got=%h expected=0000",
               product);
    end
  endtask

  task automatic test_directed();
    run_op(8'h0D, 8'h0B, 1'b0, "d_0d0b");
    n_tests++;
    if (last_exp !== 16'h008F) begin
      n_fail++;
      $display("FAIL d_0d0b const: got=%h expected=008F",
               last_exp);
    end
    run_op(8'hFF, 8'hFF, 1'b0, "d_ffff");
    n_tests++;
    if (product !== 16'hFE01) begin
      n_fail++;
      $display("FAIL d_ffff const: got=%h expected=FE01",
               product);
    end
    run_op(8'h00, 8'hFF, 1'b0, "d_00ff");
    run_op(8'hFF, 8'h00, 1'b0, "d_ff00");
  endtask

  // start held high: mid-run operands must be ignored and
  // the second accept lands on the first idle edge.
  task automatic test_back_to_back();
    @(negedge clk);
    start = 1'b1;
    a = 8'h03;
    b = 8'h05;
    @(posedge clk);
    sb.push_back(16'h000F);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      a = 8'h07;
      b = 8'h09;
      chk_bd("b2b_1", k, k <= 9, k == 9);
      if (k == 9) pop_check("b2b_1");
    end
    n_tests++;
    if (product !== 16'h000F) begin
      n_fail++;
      $display("FAIL b2b_idle product: got=%h expected=000F",
               product);
    end
    @(posedge clk);
    sb.push_back(16'h003F);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      chk_bd("b2b_2", k, k <= 9, k == 9);
      if (k == 9) pop_check("b2b_2");
    end
  endtask

  task automatic test_reset_abort();
    int pulses;
    run_op(8'h5A, 8'h33, 1'b0, "abort_pre");
    @(negedge clk);
    start = 1'b1;
    a = 8'hC3;
    b = 8'h7E;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk_bd("abort", 4, 1'b0, 1'b0);
    n_tests++;
    if (product !== 16'h0000) begin
      n_fail++;
      $display("FAIL abort product: got=%h expected=0000",
               product);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) pulses++;
    end
    n_tests++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL abort_after: active cycles=%0d expected=0",
               pulses);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'b1, "rand");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_abort();
    test_random();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL queue_empty: left=%0d expected=0",
               sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
